// File: rtl/alu_operand_b_stage.sv
// ALU source-B operand select feeding a 2-entry skid buffer.
// Illegal selects produce zero data tagged with an error bit.
module alu_operand_b_stage #(
  parameter int WIDTH     = 32,
  parameter int NUM_SRC   = 5,
  parameter int SEL_W     = 3,
  parameter int CONST_SEL = 1,
  parameter int CONST_VAL = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*WIDTH-1:0] src_bus,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               occupancy,
  output logic                     sel_err,
  input  logic                     err_clr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             head_err_q, head_err_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;
  logic             sel_err_q, sel_err_d;

  logic [WIDTH-1:0] new_data;
  logic             new_err;
  logic             accept;
  logic             drain;

  // Only slots that match exactly clear the error tag.
  always_comb begin
    new_data = '0;
    new_err  = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        new_err = 1'b0;
        if (i == CONST_SEL) begin
          new_data = WIDTH'(CONST_VAL);
        end else begin
          new_data = src_bus[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_data_q;
  assign out_err   = head_err_q;
  assign occupancy = state_q;
  assign sel_err   = sel_err_q;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_err_d  = head_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          head_data_d = new_data;
          head_err_d  = new_err;
        end
      end
      ONE: begin
        if (accept && drain) begin
          head_data_d = new_data;
          head_err_d  = new_err;
        end else if (accept) begin
          state_d     = TWO;
          skid_data_d = new_data;
          skid_err_d  = new_err;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          state_d     = ONE;
          head_data_d = skid_data_q;
          head_err_d  = skid_err_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    sel_err_d = sel_err_q;
    if (accept && new_err) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_err_q  <= head_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
      sel_err_q   <= sel_err_d;
    end
  end

endmodule

// File: tb/tb_alu_operand_b_stage.sv
// Directed bench for alu_operand_b_stage with an output scoreboard.
// Expected {err,data} words are queued on accept and matched on drain.
module tb_alu_operand_b_stage;
  localparam int W = 32;
  localparam int N = 5;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N*W-1:0] src_bus;
  logic [SW-1:0] sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_err;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    occupancy;
  logic          sel_err;
  logic          err_clr;

  int total = 0;
  int bad = 0;
  int n_out = 0;
  int n0;
  logic [W:0] q[$];

  alu_operand_b_stage dut (
    .clk(clk), .reset(reset), .src_bus(src_bus), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy), .sel_err(sel_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [SW-1:0] s,
                                       input logic [N*W-1:0] b);
    if (s == 3'd1) return {1'b0, 32'd4};
    if (s < 3'd5) return {1'b0, b[s*W +: W]};
    return {1'b1, 32'd0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [W-1:0] v);
    src_bus[i*W +: W] = v;
  endtask

  // Inputs settle #1 after posedge, so negedge sees the next edge's transfers.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          chk("unexpected_out", {31'd0, out_err, out_data}, 64'hDEAD);
        end else begin
          chk("sb_out", {31'd0, out_err, out_data}, {31'd0, q.pop_front()});
        end
      end
      if (in_valid && in_ready) q.push_back(model(sel, src_bus));
    end
  end

  initial begin
    reset = 1'b1;
    src_bus = '0;
    sel = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    err_clr = 1'b0;

    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_sel_err", 64'(sel_err), 64'd0);
    reset = 1'b0;

    set_slot(0, 32'h1234_5678);
    set_slot(1, 32'hFFFF_FFFF);
    set_slot(2, 32'h2222_2222);
    set_slot(3, 32'h3333_3333);
    set_slot(4, 32'h4444_4444);
    out_ready = 1'b1;
    sel = 3'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("sel0_valid", 64'(out_valid), 64'd1);
    chk("sel0_data", 64'(out_data), 64'h1234_5678);
    sel = 3'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("sel1_const", 64'(out_data), 64'h4);
    sel = 3'd4; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("sel4_data", 64'(out_data), 64'h4444_4444);
    step();
    chk("drain_occ", 64'(occupancy), 64'd0);

    out_ready = 1'b0;
    set_slot(0, 32'hAAAA_0001);
    set_slot(3, 32'hCCCC_0003);
    sel = 3'd0; in_valid = 1'b1;
    step();
    sel = 3'd3;
    step();
    in_valid = 1'b0;
    chk("bp_occ2", 64'(occupancy), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head_a", 64'(out_data), 64'hAAAA_0001);
    sel = 3'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_hold_a", 64'(out_data), 64'hAAAA_0001);
    chk("bp_hold_occ", 64'(occupancy), 64'd2);
    out_ready = 1'b1;
    step();
    chk("bp_head_c", 64'(out_data), 64'hCCCC_0003);
    chk("bp_occ1", 64'(occupancy), 64'd1);
    step();
    chk("bp_occ0", 64'(occupancy), 64'd0);

    n0 = n_out;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = SW'(i % 5);
      for (int k = 0; k < N; k++) set_slot(k, $urandom);
      step();
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_count", 64'(n_out - n0), 64'd8);

    sel = 3'd6; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ill_data", 64'(out_data), 64'd0);
    chk("ill_err", 64'(out_err), 64'd1);
    chk("ill_sticky_set", 64'(sel_err), 64'd1);
    step();
    chk("ill_sticky_hold", 64'(sel_err), 64'd1);
    sel = 3'd7; in_valid = 1'b1; err_clr = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ill_set_wins", 64'(sel_err), 64'd1);
    step();
    err_clr = 1'b0;
    chk("ill_clear", 64'(sel_err), 64'd0);

    out_ready = 1'b0;
    sel = 3'd2; in_valid = 1'b1;
    step();
    sel = 3'd3;
    step();
    in_valid = 1'b0;
    chk("mid_occ2", 64'(occupancy), 64'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_occ0", 64'(occupancy), 64'd0);
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    n0 = n_out;
    out_ready = 1'b1;
    step();
    step();
    step();
    chk("mid_no_emit", 64'(n_out - n0), 64'd0);
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
